// File: rtl/map_ram_ckpt.sv
// Multi-port rename map RAM with optional write-to-read bypass and
// internally allocated checkpoint slots for mispredict recovery.
module map_ram_ckpt #(
  parameter int DATAWIDTH = 8,
  parameter int INDEXSIZE = 32,
  parameter int LOGINDEX  = 5,
  parameter int NRD       = 8,
  parameter int NWR       = 4,
  parameter int NCKPT     = 4,
  parameter int LOGCKPT   = 2,
  parameter int BYPASS    = 1,
  parameter int INIT_MODE = 1,
  parameter int INITVALUE = 0
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NRD*LOGINDEX-1:0]  rd_index_in,
  output logic [NRD*DATAWIDTH-1:0] rd_data_out,
  input  logic [NWR-1:0]           we_in,
  input  logic [NWR*LOGINDEX-1:0]  wr_index_in,
  input  logic [NWR*DATAWIDTH-1:0] wr_data_in,
  input  logic                     ckpt_save_in,
  output logic                     ckpt_ack_out,
  output logic [LOGCKPT-1:0]       ckpt_id_out,
  output logic                     ckpt_full_out,
  input  logic [NCKPT-1:0]         ckpt_free_in,
  input  logic                     restore_in,
  input  logic [LOGCKPT-1:0]       restore_id_in,
  output logic [NCKPT-1:0]         ckpt_valid_out
);

  logic [DATAWIDTH-1:0] mem_q  [INDEXSIZE];
  logic [DATAWIDTH-1:0] mem_w  [INDEXSIZE];
  logic [DATAWIDTH-1:0] mem_d  [INDEXSIZE];
  logic [DATAWIDTH-1:0] snap_q [NCKPT][INDEXSIZE];
  logic [NCKPT-1:0]     valid_q, valid_d;
  logic [LOGINDEX-1:0]  rd_idx;
  logic [DATAWIDTH-1:0] rd_val;
  logic [LOGCKPT-1:0]   alloc_id;
  logic                 found;
  logic                 restore_valid;

  // Post-write map; ascending port order lets the highest port win.
  always_comb begin
    mem_w = mem_q;
    for (int unsigned p = 0; p < NWR; p++) begin
      if (we_in[p])
        mem_w[wr_index_in[p*LOGINDEX +: LOGINDEX]] = wr_data_in[p*DATAWIDTH +: DATAWIDTH];
    end
  end

  always_comb begin
    rd_data_out = '0;
    rd_idx      = '0;
    rd_val      = '0;
    for (int unsigned r = 0; r < NRD; r++) begin
      rd_idx = rd_index_in[r*LOGINDEX +: LOGINDEX];
      rd_val = mem_q[rd_idx];
      if (BYPASS == 1) begin
        for (int unsigned p = 0; p < NWR; p++) begin
          if (we_in[p] && (wr_index_in[p*LOGINDEX +: LOGINDEX] == rd_idx))
            rd_val = wr_data_in[p*DATAWIDTH +: DATAWIDTH];
        end
      end
      rd_data_out[r*DATAWIDTH +: DATAWIDTH] = rd_val;
    end
  end

  always_comb begin
    alloc_id = '0;
    found    = 1'b0;
    for (int unsigned k = 0; k < NCKPT; k++) begin
      if (!found && !valid_q[k]) begin
        alloc_id = LOGCKPT'(k);
        found    = 1'b1;
      end
    end
  end

  assign ckpt_full_out  = &valid_q;
  assign ckpt_id_out    = alloc_id;
  assign restore_valid  = restore_in & valid_q[restore_id_in];
  assign ckpt_ack_out   = ckpt_save_in & ~ckpt_full_out & ~restore_valid;
  assign ckpt_valid_out = valid_q;

  always_comb begin
    valid_d = valid_q & ~ckpt_free_in;
    if (ckpt_ack_out)
      valid_d[alloc_id] = 1'b1;
    if (restore_valid)
      valid_d[restore_id_in] = 1'b0;
    if (restore_valid)
      mem_d = snap_q[restore_id_in];
    else
      mem_d = mem_w;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < INDEXSIZE; i++) begin
        if (INIT_MODE == 1)
          mem_q[i] <= DATAWIDTH'(i);
        else
          mem_q[i] <= DATAWIDTH'(INITVALUE);
      end
      valid_q <= '0;
    end else begin
      mem_q   <= mem_d;
      valid_q <= valid_d;
    end
  end

  // Snapshot storage needs no reset; its valid bit gates every use.
  always_ff @(posedge clock) begin
    if (reset_n && ckpt_ack_out)
      snap_q[alloc_id] <= mem_w;
  end

endmodule

// File: tb/tb_map_ram_ckpt.sv
// Directed bench for map_ram_ckpt with a queue-based expectation scoreboard.
module tb_map_ram_ckpt;
  localparam int DW = 8, LI = 5, NRD = 8, NWR = 4, NC = 4, LC = 2;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [NRD*LI-1:0] rd_index_in;
  logic [NRD*DW-1:0] rd_data_out;
  logic [NWR-1:0]    we_in;
  logic [NWR*LI-1:0] wr_index_in;
  logic [NWR*DW-1:0] wr_data_in;
  logic              ckpt_save_in;
  logic              ckpt_ack_out;
  logic [LC-1:0]     ckpt_id_out;
  logic              ckpt_full_out;
  logic [NC-1:0]     ckpt_free_in;
  logic              restore_in;
  logic [LC-1:0]     restore_id_in;
  logic [NC-1:0]     ckpt_valid_out;

  map_ram_ckpt #(
    .DATAWIDTH(DW), .INDEXSIZE(32), .LOGINDEX(LI), .NRD(NRD), .NWR(NWR),
    .NCKPT(NC), .LOGCKPT(LC), .BYPASS(1), .INIT_MODE(1), .INITVALUE(0)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .rd_index_in(rd_index_in), .rd_data_out(rd_data_out),
    .we_in(we_in), .wr_index_in(wr_index_in), .wr_data_in(wr_data_in),
    .ckpt_save_in(ckpt_save_in), .ckpt_ack_out(ckpt_ack_out),
    .ckpt_id_out(ckpt_id_out), .ckpt_full_out(ckpt_full_out),
    .ckpt_free_in(ckpt_free_in), .restore_in(restore_in),
    .restore_id_in(restore_id_in), .ckpt_valid_out(ckpt_valid_out)
  );

  always #5 clock = ~clock;

  int unsigned   checks = 0;
  int unsigned   errors = 0;
  logic [31:0]   exp_q[$];
  string         tag_q[$];

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic chk(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0h required=none", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      assert (obs === e)
      else begin
        errors++;
        $error("FAIL %s observed=%0h required=%0h", t, obs, e);
      end
    end
  endtask

  task automatic idle();
    we_in = '0; wr_index_in = '0; wr_data_in = '0;
    ckpt_save_in = 1'b0; ckpt_free_in = '0;
    restore_in = 1'b0; restore_id_in = '0;
  endtask

  task automatic set_rd(input int p, input int idx);
    rd_index_in[p*LI +: LI] = LI'(idx);
  endtask

  task automatic set_wr(input int p, input int idx, input int d);
    we_in[p] = 1'b1;
    wr_index_in[p*LI +: LI] = LI'(idx);
    wr_data_in[p*DW +: DW]  = DW'(d);
  endtask

  function automatic logic [31:0] rd(input int p);
    return 32'(rd_data_out[p*DW +: DW]);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic expect_ckpt(input string tag, input int v, input int f, input int id, input int a);
    expect_v({tag, "_valid"}, 32'(v));
    expect_v({tag, "_full"},  32'(f));
    expect_v({tag, "_id"},    32'(id));
    expect_v({tag, "_ack"},   32'(a));
  endtask

  task automatic chk_ckpt();
    chk(32'(ckpt_valid_out));
    chk(32'(ckpt_full_out));
    chk(32'(ckpt_id_out));
    chk(32'(ckpt_ack_out));
  endtask

  task automatic read_one(input string tag, input int idx, input int v);
    set_rd(0, idx);
    sample();
    expect_v(tag, 32'(v));
    chk(rd(0));
  endtask

  initial begin
    idle();
    rd_index_in = '0;
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;

    // Reset state and identity map over all 32 indices.
    sample();
    expect_ckpt("reset", 0, 0, 0, 0);
    chk_ckpt();
    for (int g = 0; g < 4; g++) begin
      for (int p = 0; p < NRD; p++) set_rd(p, g*NRD + p);
      sample();
      for (int p = 0; p < NRD; p++) begin
        expect_v($sformatf("ident_%0d", g*NRD + p), 32'(g*NRD + p));
        chk(rd(p));
      end
    end

    // Two ports to index 5: highest port wins, bypassed same cycle.
    step();
    set_wr(0, 5, 'h11); set_wr(3, 5, 'h33);
    set_rd(2, 5); set_rd(1, 6);
    sample();
    expect_v("bypass_hi_port", 32'h33); chk(rd(2));
    expect_v("bypass_nomatch", 32'h06); chk(rd(1));
    step(); idle();
    sample();
    expect_v("stored_hi_port", 32'h33); chk(rd(2));

    // Save together with a write captures the post-write value.
    step();
    set_wr(1, 7, 'h40); ckpt_save_in = 1'b1;
    sample();
    expect_ckpt("save0", 0, 0, 0, 1); chk_ckpt();
    step(); idle();
    set_wr(2, 7, 'h50);
    sample();
    expect_v("valid_after_save0", 32'b0001); chk(32'(ckpt_valid_out));
    step(); idle();
    restore_in = 1'b1; restore_id_in = 2'd0;
    set_rd(0, 7);
    sample();
    expect_v("read_during_restore", 32'h50); chk(rd(0));
    step(); idle();
    read_one("restored_idx7", 7, 'h40);
    expect_v("valid_after_restore", 32'b0000); chk(32'(ckpt_valid_out));

    // Fill all four slots, each snapshot holding a distinct index-3 value.
    for (int k = 0; k < 4; k++) begin
      step(); idle();
      ckpt_save_in = 1'b1;
      if (k > 0) set_wr(0, 3, 'h20 + k);
      sample();
      expect_v($sformatf("fill_ack_%0d", k), 32'd1); chk(32'(ckpt_ack_out));
      expect_v($sformatf("fill_id_%0d", k), 32'(k)); chk(32'(ckpt_id_out));
    end
    step(); idle();
    ckpt_save_in = 1'b1;
    sample();
    expect_ckpt("full_save", 'b1111, 1, 0, 0); chk_ckpt();
    step(); idle();
    ckpt_free_in = 4'b0010;
    sample();
    expect_v("free_not_same_cycle", 32'd1); chk(32'(ckpt_full_out));
    step(); idle();
    sample();
    expect_ckpt("after_free", 'b1101, 0, 1, 0); chk_ckpt();

    // Restore beats a same-cycle write and save.
    step(); idle();
    restore_in = 1'b1; restore_id_in = 2'd2;
    set_wr(1, 3, 'h7F); ckpt_save_in = 1'b1;
    sample();
    expect_v("restore_refuses_save", 32'd0); chk(32'(ckpt_ack_out));
    step(); idle();
    read_one("snap2_idx3", 3, 'h22);
    read_one("snap2_idx5", 5, 'h33);
    read_one("snap2_idx7", 7, 'h40);
    expect_v("valid_after_restore2", 32'b1001); chk(32'(ckpt_valid_out));

    // Restore of an invalid slot is ignored; write and save proceed.
    step(); idle();
    restore_in = 1'b1; restore_id_in = 2'd2;
    set_wr(1, 3, 'h7F); ckpt_save_in = 1'b1;
    sample();
    expect_v("inv_restore_ack", 32'd1); chk(32'(ckpt_ack_out));
    expect_v("inv_restore_id", 32'd1); chk(32'(ckpt_id_out));
    step(); idle();
    read_one("inv_restore_write", 3, 'h7F);
    expect_v("valid_after_inv", 32'b1011); chk(32'(ckpt_valid_out));

    // Save slot 2 while freeing slot 0: both apply.
    step(); idle();
    ckpt_save_in = 1'b1; ckpt_free_in = 4'b0001;
    sample();
    expect_v("save_free_id", 32'd2); chk(32'(ckpt_id_out));
    step(); idle();
    sample();
    expect_v("save_free_valid", 32'b1110); chk(32'(ckpt_valid_out));
    step(); idle();
    ckpt_save_in = 1'b1;
    step(); idle();
    sample();
    expect_v("all_valid", 32'b1111); chk(32'(ckpt_valid_out));

    // Reset overrides a pending restore and write.
    step();
    reset_n = 1'b0;
    restore_in = 1'b1; restore_id_in = 2'd1;
    set_wr(0, 3, 'h55);
    step(); idle();
    reset_n = 1'b1;
    sample();
    expect_ckpt("mid_reset", 0, 0, 0, 0); chk_ckpt();
    read_one("mid_reset_idx3", 3, 3);
    read_one("mid_reset_idx7", 7, 7);
    read_one("mid_reset_idx5", 5, 5);

    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
